// File: rtl/output_requantizer.sv
// output_requantizer: rounds, right-shifts, optionally ReLUs and saturates
// finished MAC accumulator values. Results go through a small FIFO to a
// valid/ready output port. The input side cannot be stalled, so a sample
// that arrives at a full FIFO is dropped and the sticky overflow flag is set.
module output_requantizer #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    parameter int FIFO_DEPTH         = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_in,
    input  logic signed [ACCUMULATION_WIDTH-1:0]    acc_in,
    input  logic                                    acc_valid,
    input  logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    acc_x,
    input  logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   acc_y,
    input  logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   acc_ch,
    input  logic [$clog2(ACCUMULATION_WIDTH)-1:0]   shift,
    input  logic                                    relu_en,
    output logic signed [IO_DATA_WIDTH-1:0]         out_data,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]    out_x,
    output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0]   out_y,
    output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0]   out_ch,
    output logic [$clog2(FIFO_DEPTH):0]             fifo_level,
    output logic                                    overflow,
    output logic [15:0]                             sat_count
);

    localparam int AW  = ACCUMULATION_WIDTH;
    localparam int IOW = IO_DATA_WIDTH;
    localparam int XW  = $clog2(FEATURE_MAP_WIDTH);
    localparam int YW  = $clog2(FEATURE_MAP_HEIGHT);
    localparam int CW  = $clog2(OUTPUT_NB_CHANNELS);
    localparam int SW  = $clog2(ACCUMULATION_WIDTH);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int LW  = PW + 1;

    localparam logic signed [AW:0] SAT_MAX = (AW+1)'((2 ** (IOW - 1)) - 1);
    localparam logic signed [AW:0] SAT_MIN = ~SAT_MAX;
    localparam logic [LW-1:0]      DEPTH_L = LW'(FIFO_DEPTH);

    // ---------------- S1: round-half-up arithmetic shift ----------------
    logic signed [AW:0] w_ext;
    logic signed [AW:0] w_rnd;
    logic signed [AW:0] w_sum;
    logic signed [AW:0] w_shr;
    logic [SW-1:0]      w_shm1;

    logic               r_s1_valid;
    logic signed [AW:0] r_s1_val;
    logic [XW-1:0]      r_s1_x;
    logic [YW-1:0]      r_s1_y;
    logic [CW-1:0]      r_s1_ch;
    logic               r_s1_relu;

    // Sign-extend by one bit so adding the rounding constant cannot overflow
    always_comb begin
        w_ext  = {acc_in[AW-1], acc_in};
        w_shm1 = shift - SW'(1);
        w_rnd  = '0;
        if (shift != '0) begin
            w_rnd[w_shm1] = 1'b1;
        end
        w_sum = w_ext + w_rnd;
        w_shr = w_sum >>> shift;
    end

    // S1 valid flag
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= acc_valid;
        end
    end

    // S1 payload capture
    always_ff @(posedge clk) begin
        if (acc_valid) begin
            r_s1_val  <= w_shr;
            r_s1_x    <= acc_x;
            r_s1_y    <= acc_y;
            r_s1_ch   <= acc_ch;
            r_s1_relu <= relu_en;
        end
    end

    // ---------------- S2: ReLU and saturation ----------------
    logic signed [AW:0]  w_relu_val;
    logic                w_hi;
    logic                w_lo;
    logic [IOW-1:0]      w_sat_data;

    logic                r_s2_valid;
    logic                r_s2_clip;
    logic [IOW-1:0]      r_s2_data;
    logic [XW-1:0]       r_s2_x;
    logic [YW-1:0]       r_s2_y;
    logic [CW-1:0]       r_s2_ch;

    // ReLU first so zeroed negatives never register as clipped
    always_comb begin
        w_relu_val = r_s1_val;
        if (r_s1_relu && r_s1_val[AW]) begin
            w_relu_val = '0;
        end
        w_hi = (w_relu_val > SAT_MAX);
        w_lo = (w_relu_val < SAT_MIN);
        if (w_hi) begin
            w_sat_data = SAT_MAX[IOW-1:0];
        end else if (w_lo) begin
            w_sat_data = SAT_MIN[IOW-1:0];
        end else begin
            w_sat_data = w_relu_val[IOW-1:0];
        end
    end

    // S2 valid flag
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_s2_valid <= 1'b0;
        end else begin
            r_s2_valid <= r_s1_valid;
        end
    end

    // S2 payload capture
    always_ff @(posedge clk) begin
        if (r_s1_valid) begin
            r_s2_clip <= w_hi || w_lo;
            r_s2_data <= w_sat_data;
            r_s2_x    <= r_s1_x;
            r_s2_y    <= r_s1_y;
            r_s2_ch   <= r_s1_ch;
        end
    end

    // ---------------- Output FIFO ----------------
    logic [IOW-1:0] r_mem_data [FIFO_DEPTH];
    logic [XW-1:0]  r_mem_x    [FIFO_DEPTH];
    logic [YW-1:0]  r_mem_y    [FIFO_DEPTH];
    logic [CW-1:0]  r_mem_ch   [FIFO_DEPTH];

    logic [PW-1:0]  r_wr_ptr;
    logic [PW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;
    logic           r_overflow;
    logic [15:0]    r_sat_count;

    logic           w_full;
    logic           w_pop;
    logic           w_push;

    // A push into a full FIFO is accepted only when a pop frees the slot
    always_comb begin
        w_full = (r_level == DEPTH_L);
        w_pop  = out_valid && out_ready;
        w_push = r_s2_valid && (!w_full || w_pop);
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= r_s2_data;
            r_mem_x[r_wr_ptr]    <= r_s2_x;
            r_mem_y[r_wr_ptr]    <= r_s2_y;
            r_mem_ch[r_wr_ptr]   <= r_s2_ch;
        end
    end

    // Pointers, occupancy, sticky overflow and saturating clip counter
    always_ff @(posedge clk) begin
        if (rst_in) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_overflow  <= 1'b0;
            r_sat_count <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (r_s2_valid && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (r_s2_valid && r_s2_clip && (r_sat_count != '1)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
        end
    end

    // Head of FIFO shown combinationally; forced to zero while empty
    assign out_valid  = (r_level != '0);
    assign out_data   = out_valid ? r_mem_data[r_rd_ptr] : '0;
    assign out_x      = out_valid ? r_mem_x[r_rd_ptr]    : '0;
    assign out_y      = out_valid ? r_mem_y[r_rd_ptr]    : '0;
    assign out_ch     = out_valid ? r_mem_ch[r_rd_ptr]   : '0;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign sat_count  = r_sat_count;

endmodule

// File: tb/tb_output_requantizer.sv
// Directed self-checking bench for output_requantizer (default parameters).
module tb_output_requantizer;

    logic        clk = 1'b0;
    logic        rst_in = 1'b1;
    logic [31:0] acc_in = '0;
    logic        acc_valid = 1'b0;
    logic [9:0]  acc_x = '0;
    logic [9:0]  acc_y = '0;
    logic [5:0]  acc_ch = '0;
    logic [4:0]  shift = '0;
    logic        relu_en = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [9:0]  out_x;
    logic [9:0]  out_y;
    logic [5:0]  out_ch;
    logic [2:0]  fifo_level;
    logic        overflow;
    logic [15:0] sat_count;

    int total = 0;
    int bad = 0;

    output_requantizer #(
        .ACCUMULATION_WIDTH(32),
        .IO_DATA_WIDTH(16),
        .FEATURE_MAP_WIDTH(1024),
        .FEATURE_MAP_HEIGHT(1024),
        .OUTPUT_NB_CHANNELS(64),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst_in(rst_in),
        .acc_in(acc_in),
        .acc_valid(acc_valid),
        .acc_x(acc_x),
        .acc_y(acc_y),
        .acc_ch(acc_ch),
        .shift(shift),
        .relu_en(relu_en),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_x(out_x),
        .out_y(out_y),
        .out_ch(out_ch),
        .fifo_level(fifo_level),
        .overflow(overflow),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic [9:0] x, input logic [9:0] y, input logic [5:0] ch);
        acc_valid = 1'b1;
        acc_in    = a;
        acc_x     = x;
        acc_y     = y;
        acc_ch    = ch;
    endtask

    task automatic do_reset;
        rst_in    = 1'b1;
        acc_valid = 1'b0;
        tick();
        rst_in    = 1'b0;
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        rst_in = 1'b0;
        chk("rst_valid", out_valid, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_sat", sat_count, 0);
        chk("rst_data", out_data, 0);

        // Passthrough with exact latency
        shift = 5'd0; relu_en = 1'b0; out_ready = 1'b1;
        drive(32'd100, 10'd3, 10'd7, 6'd5);
        tick();
        acc_valid = 1'b0;
        chk("pt_valid_t1", out_valid, 0);
        tick();
        chk("pt_valid_t2", out_valid, 0);
        tick();
        chk("pt_valid_t3", out_valid, 1);
        chk("pt_data", out_data, 100);
        chk("pt_x", out_x, 3);
        chk("pt_y", out_y, 7);
        chk("pt_ch", out_ch, 5);
        chk("pt_level", fifo_level, 1);
        chk("pt_sat", sat_count, 0);
        tick();
        chk("pt_valid_t4", out_valid, 0);

        // Rounding and saturation, shift=4
        shift = 5'd4;
        drive(32'd24, 10'd1, 10'd0, 6'd0);
        tick();
        drive(32'hFFFF_FFE8, 10'd2, 10'd0, 6'd0);
        tick();
        drive(32'h7FFF_FFFF, 10'd3, 10'd0, 6'd0);
        tick();
        chk("rnd_pos_data", out_data, 16'h0002);
        chk("rnd_pos_sat", sat_count, 0);
        drive(32'h8000_0000, 10'd4, 10'd0, 6'd0);
        tick();
        acc_valid = 1'b0;
        chk("rnd_neg_data", out_data, 16'hFFFF);
        chk("rnd_neg_x", out_x, 2);
        tick();
        chk("sat_hi_data", out_data, 16'h7FFF);
        chk("sat_hi_cnt", sat_count, 1);
        tick();
        chk("sat_lo_data", out_data, 16'h8000);
        chk("sat_lo_cnt", sat_count, 2);
        tick();
        chk("rnd_drained", out_valid, 0);

        // ReLU, shift=0
        shift = 5'd0; relu_en = 1'b1;
        drive(32'hFFFF_FC18, 10'd0, 10'd0, 6'd0);
        tick();
        drive(32'hFFFE_7960, 10'd0, 10'd0, 6'd0);
        tick();
        drive(32'h0000_9C40, 10'd0, 10'd0, 6'd0);
        tick();
        acc_valid = 1'b0;
        chk("relu_m1000", out_data, 0);
        chk("relu_m1000_sat", sat_count, 2);
        tick();
        chk("relu_m100000", out_data, 0);
        chk("relu_m100000_sat", sat_count, 2);
        tick();
        chk("relu_40000", out_data, 16'h7FFF);
        chk("relu_40000_sat", sat_count, 3);
        tick();
        chk("relu_drained", out_valid, 0);

        // Overflow: no consumer, six back-to-back samples
        relu_en = 1'b0; out_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            drive(32'(i), 10'(i), 10'd0, 6'd0);
            tick();
        end
        acc_valid = 1'b0;
        chk("ovf_full_level", fifo_level, 4);
        chk("ovf_not_yet", overflow, 0);
        tick();
        chk("ovf_set", overflow, 1);
        tick();
        chk("ovf_level", fifo_level, 4);
        chk("ovf_sticky", overflow, 1);
        out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("ovf_drain_valid", out_valid, 1);
            chk("ovf_drain_data", out_data, 32'(k));
            chk("ovf_drain_x", out_x, 32'(k));
            tick();
        end
        chk("ovf_empty", out_valid, 0);
        chk("ovf_empty_level", fifo_level, 0);
        chk("ovf_hold", overflow, 1);

        do_reset();
        chk("rst2_ovf", overflow, 0);
        chk("rst2_sat", sat_count, 0);

        // Full FIFO with simultaneous push and pop
        out_ready = 1'b0;
        begin
            int exp_head;
            exp_head = 1;
            for (int cyc = 0; cyc <= 20; cyc++) begin
                acc_valid = (cyc < 14);
                acc_in    = 32'(cyc + 1);
                acc_x     = 10'(cyc + 1);
                out_ready = (cyc >= 6);
                if (cyc >= 6 && cyc <= 16) begin
                    chk("fp_level", fifo_level, 4);
                    chk("fp_ovf", overflow, 0);
                end
                if (cyc >= 6 && cyc <= 19) begin
                    chk("fp_valid", out_valid, 1);
                    chk("fp_data", out_data, 32'(exp_head));
                    chk("fp_x", out_x, 32'(exp_head));
                    exp_head++;
                end
                if (cyc == 20) begin
                    chk("fp_empty", out_valid, 0);
                    chk("fp_ovf_end", overflow, 0);
                end
                tick();
            end
        end

        // Reset mid-stream with FIFO at 3 and both stages busy
        out_ready = 1'b0; shift = 5'd0; relu_en = 1'b0;
        drive(32'd40000, 10'd9, 10'd9, 6'd9);
        tick();
        for (int i = 2; i <= 5; i++) begin
            drive(32'(i), 10'(i), 10'd0, 6'd0);
            tick();
        end
        chk("mr_level3", fifo_level, 3);
        chk("mr_sat1", sat_count, 1);
        do_reset();
        chk("mr_valid", out_valid, 0);
        chk("mr_level", fifo_level, 0);
        chk("mr_ovf", overflow, 0);
        chk("mr_sat", sat_count, 0);
        tick();
        tick();
        tick();
        chk("mr_flushed", fifo_level, 0);
        out_ready = 1'b1;
        drive(32'd77, 10'd1, 10'd2, 6'd3);
        tick();
        acc_valid = 1'b0;
        tick();
        chk("mr_new_t2", out_valid, 0);
        tick();
        chk("mr_new_t3", out_valid, 1);
        chk("mr_new_data", out_data, 77);
        chk("mr_new_x", out_x, 1);
        chk("mr_new_y", out_y, 2);
        chk("mr_new_ch", out_ch, 3);
        tick();
        chk("mr_new_gone", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
